// File: rtl/pulse_stretch.sv
// Pulse stretcher: each accepted trigger holds z high for HIGH_CYC cycles, then a GAP_CYC lockout.
// Define PULSE_STRETCH_RETRIGGER_EN to let triggers during ACTIVE restart the high period.
module pulse_stretch #(
  parameter int unsigned HIGH_CYC = 8,
  parameter int unsigned GAP_CYC  = 2,
  parameter int unsigned CW       = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic p,
  input  logic en,
  output logic z,
  output logic done,
  output logic busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] GAP    = 2'd2;

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYC == 0) ? '0 : CW'(GAP_CYC - 1);

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIGGER = 1'b1;
`else
  localparam bit RETRIGGER = 1'b0;
`endif

  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          trig_c;

  assign trig_c = p & en;

  // Next-state and counter logic; encoding 2'b11 falls back to IDLE.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (trig_c) begin
          state_nx = ACTIVE;
          cnt_nx   = HIGH_LOAD;
        end
      end
      ACTIVE: begin
        if (RETRIGGER && trig_c) begin
          cnt_nx = HIGH_LOAD;
        end else if (cnt == '0) begin
          if (GAP_CYC == 0) begin
            state_nx = IDLE;
            cnt_nx   = '0;
          end else begin
            state_nx = GAP;
            cnt_nx   = GAP_LOAD;
          end
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      z     <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      z     <= (state_nx == ACTIVE);
      done  <= (state == ACTIVE) && (state_nx != ACTIVE);
      busy  <= (state_nx == ACTIVE) || (state_nx == GAP);
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// Bench for pulse_stretch: three parameterisations driven in parallel against a timeline model.
module tb_pulse_stretch;

  logic clk = 1'b0;
  logic rst, p, en;
  logic [2:0] z, done, busy;

  always #5 clk = ~clk;

  pulse_stretch #(.HIGH_CYC(8), .GAP_CYC(2), .CW(8)) u0 (
    .clk(clk), .rst(rst), .p(p), .en(en), .z(z[0]), .done(done[0]), .busy(busy[0]));
  pulse_stretch #(.HIGH_CYC(1), .GAP_CYC(0), .CW(8)) u1 (
    .clk(clk), .rst(rst), .p(p), .en(en), .z(z[1]), .done(done[1]), .busy(busy[1]));
  pulse_stretch #(.HIGH_CYC(3), .GAP_CYC(1), .CW(2)) u2 (
    .clk(clk), .rst(rst), .p(p), .en(en), .z(z[2]), .done(done[2]), .busy(busy[2]));

  int hc[3] = '{8, 1, 3};
  int gc[3] = '{2, 0, 1};

  // Timeline model: first/last z-high cycle, done cycle, last busy cycle.
  int zs[3], ze[3], da[3], be[3];
  int cyc = 0;
  int vectors = 0;
  int errors = 0;

`ifdef PULSE_STRETCH_RETRIGGER_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  // Apply the inputs sampled at the edge closing cycle c.
  function automatic void model_edge(int c, logic r, logic pp, logic ee);
    for (int k = 0; k < 3; k++) begin
      if (r) begin
        zs[k] = 0; ze[k] = -1; da[k] = -1; be[k] = -1;
      end else if (pp && ee) begin
        if (c > be[k]) begin
          zs[k] = c + 1;
          ze[k] = c + hc[k];
          da[k] = c + hc[k] + 1;
          be[k] = c + hc[k] + gc[k];
        end else if (RETRIG && c >= zs[k] && c <= ze[k]) begin
          ze[k] = c + hc[k];
          da[k] = ze[k] + 1;
          be[k] = ze[k] + gc[k];
        end
      end
    end
  endfunction

  function automatic logic [2:0] model_out(int k, int c);
    return {c >= zs[k] && c <= ze[k], c == da[k], c >= zs[k] && c <= be[k]};
  endfunction

  task automatic test_reset();
    logic [2:0] exp, obs;
    rst = 1'b1; p = 1'b1; en = 1'b1;
    repeat (2) @(posedge clk);
    model_edge(cyc, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = 3'b000;
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL reset dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      rst = (i < 1); p = 1'b1; en = 1'b1;
      if (i < 1) model_edge(cyc, 1'b1, 1'b1, 1'b1);
      else begin rst = 1'b1; model_edge(cyc, 1'b1, 1'b1, 1'b1); end
    end
    rst = 1'b0; p = 1'b0; en = 1'b0;
  endtask

  task automatic test_single();
    logic [2:0] exp, obs;
    int zcnt = 0, dcnt = 0, bcnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = model_out(k, cyc);
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL single dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      zcnt += int'(z[0]); dcnt += int'(done[0]); bcnt += int'(busy[0]);
      rst = 1'b0; en = 1'b1; p = (i == 1);
      model_edge(cyc, rst, p, en);
    end
    vectors++;
    if (zcnt != 8 || dcnt != 1 || bcnt != 10) begin
      errors++;
      $display("FAIL single_len got z=%0d done=%0d busy=%0d expected 8 1 10", zcnt, dcnt, bcnt);
    end
  endtask

  task automatic test_held();
    logic [2:0] exp, obs;
    int rises = 0;
    logic zq = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = model_out(k, cyc);
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL held dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      if (z[0] && !zq) rises++;
      zq = z[0];
      rst = 1'b0; en = 1'b1; p = (i < 26);
      model_edge(cyc, rst, p, en);
    end
    vectors++;
    if (rises != 3 - int'(RETRIG) * 2) begin
      errors++;
      $display("FAIL held_period got %0d z rises expected %0d", rises, 3 - int'(RETRIG) * 2);
    end
  endtask

  task automatic test_en_low();
    logic [2:0] exp, obs;
    int seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = model_out(k, cyc);
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL en_low dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      if (i > 12) seen += int'(z != 0) + int'(busy != 0) + int'(done != 0);
      rst = 1'b0; en = 1'b0; p = (i % 3 == 0);
      model_edge(cyc, rst, p, en);
    end
    vectors++;
    if (seen != 0) begin
      errors++;
      $display("FAIL en_low_quiet got %0d active samples expected 0", seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp, obs;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = model_out(k, cyc);
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL reset_mid dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      en = 1'b1; rst = (i == 5); p = (i == 1 || i == 7);
      model_edge(cyc, rst, p, en);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp, obs;
    int zcnt = 0, dcnt = 0;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = model_out(k, cyc);
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL back_to_back dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      zcnt += int'(z[0]); dcnt += int'(done[0]);
      rst = 1'b0; en = (i != 6) || 1'b1; p = (i == 1 || i == 6);
      model_edge(cyc, rst, p, en);
    end
    vectors++;
    if (zcnt != (RETRIG ? 13 : 8) || dcnt != 1) begin
      errors++;
      $display("FAIL b2b_len got z=%0d done=%0d expected %0d 1", zcnt, dcnt, RETRIG ? 13 : 8);
    end
  endtask

  task automatic test_random();
    logic [2:0] exp, obs;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1; cyc++;
      for (int k = 0; k < 3; k++) begin
        exp = model_out(k, cyc);
        obs = {z[k], done[k], busy[k]};
        vectors++;
        if (obs !== exp) begin
          errors++;
          $display("FAIL random dut%0d cyc %0d got zdb=%b expected %b", k, cyc, obs, exp);
        end
      end
      rst = ($urandom_range(63) == 0);
      p   = ($urandom_range(3) == 0);
      en  = ($urandom_range(3) != 0);
      model_edge(cyc, rst, p, en);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      zs[k] = 0; ze[k] = -1; da[k] = -1; be[k] = -1;
    end
    test_reset();
    test_single();
    test_held();
    test_en_low();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001 Parameter HIGH_CYC, default 8: number of clock cycles z is held high per accepted pulse; legal range 1..2^CW-1.
REQ-002 Parameter GAP_CYC, default 2: lockout cycles after z falls; legal range 0..2^CW-1.
REQ-003 Parameter CW, default 8: width of the internal down-counter.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 p  input  1  trigger pulse (typically the single-cycle output of an edge detector); sampled every posedge clk.
REQ-007 en  input  1  trigger enable; when low, p is ignored and no new stretch starts.
REQ-008 z  output  1  stretched level; registered, high exactly while in ACTIVE.
REQ-009 done  output  1  registered single-cycle pulse, high for the one cycle following the last ACTIVE cycle.
REQ-010 busy  output  1  registered; high in ACTIVE and GAP.

Function
REQ-011 FSM SHALL have three states: IDLE, ACTIVE, GAP; unused encodings SHALL return to IDLE on the next clock.
REQ-012 IDLE: p=1 and en=1 at a clock edge -> ACTIVE, counter loaded with HIGH_CYC-1; otherwise stay.
REQ-013 Latency: z SHALL rise on the clock edge that samples the accepted p (visible from the following cycle), no combinational path from p to z.
REQ-014 ACTIVE: counter decrements by 1 per cycle; when counter==0, next state is GAP (GAP_CYC>0) or IDLE (GAP_CYC==0).
REQ-015 z SHALL be high for exactly HIGH_CYC consecutive cycles per non-retriggered pulse.
REQ-016 On exit from ACTIVE, done SHALL be 1 for exactly one cycle, coincident with z's first low cycle.
REQ-017 GAP: counter loaded with GAP_CYC-1 on entry, decrements each cycle; counter==0 -> IDLE; p ignored throughout GAP.
REQ-018 Pulse arriving on the same edge that GAP->IDLE occurs SHALL be ignored; acceptance needs state==IDLE at the sampling edge.
REQ-019 With GAP_CYC==0 a p sampled on the edge ACTIVE->IDLE is ignored; a p on the next edge starts a new stretch (minimum 1 low cycle between stretches).
REQ-020 en deasserted during ACTIVE or GAP SHALL not abort the sequence.
REQ-021 Counter arithmetic is unsigned CW bits; no wrap-around SHALL occur for legal parameters.

Reset
REQ-022 rst=1 at a clock edge SHALL force state IDLE, counter 0, z=0, done=0, busy=0, overriding p and en.
REQ-023 rst asserted mid-ACTIVE or mid-GAP SHALL terminate immediately with no done pulse; first trigger accepted on the first edge with rst=0.

Configuration
REQ-024 Macro PULSE_STRETCH_RETRIGGER_EN defined: p=1 and en=1 sampled in ACTIVE SHALL reload counter with HIGH_CYC-1, extending z so it stays high HIGH_CYC cycles after the last accepted pulse; done fires once at final exit.
REQ-025 Macro PULSE_STRETCH_RETRIGGER_EN undefined: p in ACTIVE SHALL be ignored; z length fixed at HIGH_CYC.

Verification
REQ-026 Defaults, reset then single p pulse at cycle 10 -> z high cycles 11..18, done high cycle 19, busy high 11..20, low from 21.
REQ-027 Defaults, p held high continuously from cycle 10 -> z high 11..18, low 19..21, high again 22..29 (period 11).
REQ-028 Defaults, en=0 with p pulse -> z, busy, done stay 0.
REQ-029 Defaults, rst at cycle 14 during ACTIVE -> z=0 from cycle 15, no done; new p at 16 -> z high 17..24.
REQ-030 RETRIGGER_EN defined, p at cycles 10 and 15 -> z high 11..23, single done at 24; undefined -> z high 11..18, second pulse ignored.
REQ-031 HIGH_CYC=1, GAP_CYC=0, p at 10 and 12 -> z high at 11 and 13, done at 12 and 14.
